// File: rtl/uart_io_ctrl_pkg.sv
// uart_io_ctrl_pkg
// Shared definitions for the UART byte-path controller:
//   - mode encodings driven by the sequencer (idle / load / exec)
//   - state types for the IN request FSM and the TX drain FSM
package uart_io_ctrl_pkg;

    localparam logic [2:0] MODE_IDLE = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_EXEC = 3'd2;

    typedef enum logic [1:0] {
        I_IDLE,
        I_READ,
        I_DONE
    } in_fsm_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_READ,
        T_LOAD,
        T_WAIT,
        A_START,
        A_WAIT
    } tx_fsm_t;

endpackage

// File: rtl/uart_io_ctrl_if.sv
// uart_io_ctrl_if
// Bundles the two handshakes the controller sits between:
//   serdes side : rx_valid/rx_data from uart_rx, tx_busy/tx_start/tx_data to uart_tx
//   execute side: in_req/in_ack/in_data (IN) and out_req/out_data/out_ack (OUT)
// The slave modport is the controller's view; master is the surrounding system.
interface uart_io_ctrl_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    logic       in_req;
    logic       in_ack;
    logic [7:0] in_data;

    logic       out_req;
    logic [7:0] out_data;
    logic       out_ack;

    modport master (
        output rx_valid, rx_data, tx_busy, in_req, out_req, out_data,
        input  tx_start, tx_data, in_ack, in_data, out_ack
    );

    modport slave (
        input  rx_valid, rx_data, tx_busy, in_req, out_req, out_data,
        output tx_start, tx_data, in_ack, in_data, out_ack
    );

endinterface

// File: rtl/uart_io_ctrl_fifo.sv
// io_ring_fifo
// Byte ring buffer with 2^ADDR_W slots, one of which is always left unused so
// that full (top+1==bot) and empty (top==bot) are distinguishable.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers and dout cleared)
//   push, din  : write din at top when not full
//   pop        : read at bot when not empty; dout is valid the following cycle
//   dout       : registered read data
//   full, empty: occupancy flags from the current pointers
module io_ring_fifo #(
    parameter int ADDR_W = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] bot;
    logic [ADDR_W-1:0] top_next;
    logic [ADDR_W-1:0] bot_next;

    assign top_next = top + ADDR_W'(1);
    assign bot_next = bot + ADDR_W'(1);
    assign empty    = (top == bot);
    assign full     = (top_next == bot);

    // RAM array has no reset so it maps onto block RAM; a reset only needs
    // to zero the pointers to discard the contents.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[top] <= din;
        end
    end

    // A pop never addresses the slot being pushed (bot != top when not
    // empty), so same-cycle push and pop need no bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top  <= '0;
            bot  <= '0;
            dout <= '0;
        end else begin
            if (push && !full) begin
                top <= top_next;
            end
            if (pop && !empty) begin
                dout <= mem[bot];
                bot  <= bot_next;
            end
        end
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl
// Sequences the UART byte path for the execute stage. Owns an RX and a TX
// ring buffer, serves IN/OUT requests with req/ack handshakes and sends the
// one-shot boot byte when in load mode.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   mode        : MODE_IDLE / MODE_LOAD / MODE_EXEC
//   io          : serdes and execute handshakes (uart_io_ctrl_if.slave)
//   aa_sent     : sticky, boot byte fully transmitted
//   rx_overflow : sticky, a received byte was dropped because RX was full
module uart_io_ctrl
    import uart_io_ctrl_pkg::*;
#(
    parameter int         ADDR_W  = 11,
    parameter logic [7:0] AA_BYTE = 8'hAA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    mode,
    uart_io_ctrl_if.slave io,
    output logic          aa_sent,
    output logic          rx_overflow
);

    in_fsm_t    in_state;
    tx_fsm_t    tx_state;

    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;

    logic       in_ack_r, out_ack_r, tx_start_r;
    logic [7:0] in_data_r, tx_data_r;

    assign io.in_ack   = in_ack_r;
    assign io.in_data  = in_data_r;
    assign io.out_ack  = out_ack_r;
    assign io.tx_start = tx_start_r;
    assign io.tx_data  = tx_data_r;

    // Bytes are only captured while executing; anything arriving in other
    // modes belongs to the loader and is not ours to buffer.
    assign rx_push = (mode == MODE_EXEC) && io.rx_valid && !rx_full;
    assign rx_pop  = (in_state == I_IDLE) && io.in_req && !rx_empty;

    // out_ack gates the accept so a request still held during its ack cycle
    // is not enqueued twice.
    assign tx_push = io.out_req && !out_ack_r && !tx_full;

    // Draining is suspended in load mode; the boot byte has priority and
    // queued bytes wait for the mode to change.
    assign tx_pop  = (tx_state == T_IDLE) && !(mode == MODE_LOAD)
                     && !io.tx_busy && !tx_empty;

    io_ring_fifo #(.ADDR_W(ADDR_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (io.rx_data),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    io_ring_fifo #(.ADDR_W(ADDR_W)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (io.out_data),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Overflow is only flagged for bytes that would have been stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overflow <= 1'b0;
        end else if ((mode == MODE_EXEC) && io.rx_valid && rx_full) begin
            rx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ack_r <= 1'b0;
        end else begin
            out_ack_r <= tx_push;
        end
    end

    // IN FSM: pop, wait one cycle for the RAM read, latch, then ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state  <= I_IDLE;
            in_ack_r  <= 1'b0;
            in_data_r <= '0;
        end else begin
            in_ack_r <= 1'b0;
            case (in_state)
                I_IDLE: begin
                    if (rx_pop) begin
                        in_state <= I_READ;
                    end
                end
                I_READ: begin
                    in_data_r <= rx_dout;
                    in_ack_r  <= 1'b1;
                    in_state  <= I_DONE;
                end
                I_DONE: begin
                    in_state <= I_IDLE;
                end
                default: in_state <= I_IDLE;
            endcase
        end
    end

    // TX FSM: drains the TX buffer into uart_tx or sends the boot byte.
    // In both wait states the start-pulse cycle itself is skipped, because
    // uart_tx cannot have raised tx_busy yet for the byte just launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= T_IDLE;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            aa_sent    <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (tx_state)
                T_IDLE: begin
                    if ((mode == MODE_LOAD) && !aa_sent) begin
                        tx_state <= A_START;
                    end else if (tx_pop) begin
                        tx_state <= T_READ;
                    end
                end
                T_READ: begin
                    tx_state <= T_LOAD;
                end
                T_LOAD: begin
                    tx_data_r  <= tx_dout;
                    tx_start_r <= 1'b1;
                    tx_state   <= T_WAIT;
                end
                T_WAIT: begin
                    if (!tx_start_r && !io.tx_busy) begin
                        tx_state <= T_IDLE;
                    end
                end
                A_START: begin
                    tx_data_r  <= AA_BYTE;
                    tx_start_r <= 1'b1;
                    tx_state   <= A_WAIT;
                end
                A_WAIT: begin
                    if (!tx_start_r && !io.tx_busy) begin
                        aa_sent  <= 1'b1;
                        tx_state <= T_IDLE;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

endmodule
